// File: rtl/branch_resolve_predict.sv
// Branch resolution against comparator results, plus a direct-mapped table of
// 2-bit saturating counters for taken/not-taken prediction and branch statistics.
module branch_resolve_predict #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [2:0]       res_funct3,
    input  logic             res_pred_taken,
    output logic             brun,
    input  logic             breq,
    input  logic             brlt,
    output logic             br_taken,
    output logic             mispredict,
    output logic             illegal_br,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StSnt = 2'b00,
        StWnt = 2'b01,
        StWt  = 2'b10,
        StSt  = 2'b11
    } ctr_e;

    ctr_e             table_q [DEPTH];
    ctr_e             res_state;
    ctr_e             upd_state;
    logic [1:0]       pred_state;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             legal;
    logic             taken_raw;
    logic             update;
    logic             unused_pc;

    assign pred_idx  = pred_pc[IDX_W+1:2];
    assign res_idx   = res_pc[IDX_W+1:2];
    assign unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                         res_pc[PC_W-1:IDX_W+2], res_pc[1:0]};

    // Prediction read has no bypass: a same-cycle update shows up next cycle.
    assign pred_state = table_q[pred_idx];
    assign pred_taken = pred_state[1];

    assign brun   = (res_funct3[2:1] == 2'b11);
    assign legal  = (res_funct3[2:1] != 2'b01);
    assign update = res_valid & legal;

    always_comb begin
        taken_raw = 1'b0;
        case (res_funct3)
            3'b000:  taken_raw = breq;
            3'b001:  taken_raw = ~breq;
            3'b100:  taken_raw = brlt;
            3'b101:  taken_raw = ~brlt;
            3'b110:  taken_raw = brlt;
            3'b111:  taken_raw = ~brlt;
            default: taken_raw = 1'b0;
        endcase
    end

    assign br_taken   = update & taken_raw;
    assign mispredict = update & (br_taken != res_pred_taken);
    assign illegal_br = res_valid & ~legal;

    assign res_state = table_q[res_idx];

    always_comb begin
        upd_state = res_state;
        unique case (res_state)
            StSnt: upd_state = br_taken ? StWnt : StSnt;
            StWnt: upd_state = br_taken ? StWt  : StSnt;
            StWt:  upd_state = br_taken ? StSt  : StWnt;
            StSt:  upd_state = br_taken ? StSt  : StWt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= StWnt;
            end
        end else if (update) begin
            table_q[res_idx] <= upd_state;
        end
    end

    // Clear has priority over a coincident event; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (cnt_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (update && branch_cnt != CNT_MAX) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict && mispred_cnt != CNT_MAX) begin
                mispred_cnt <= mispred_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Scoreboard bench for branch_resolve_predict: the driver pushes expected
// responses from an operand-level reference model; a negedge monitor compares.
module tb_branch_resolve_predict;

    localparam int IW   = 4;
    localparam int PW   = 32;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] pred_pc;
    logic          pred_taken;
    logic          res_valid;
    logic [PW-1:0] res_pc;
    logic [2:0]    res_funct3;
    logic          res_pred_taken;
    logic          brun;
    logic          breq;
    logic          brlt;
    logic          br_taken;
    logic          mispredict;
    logic          illegal_br;
    logic          cnt_clr;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispred_cnt;

    logic [7:0] opa;
    logic [7:0] opb;
    logic       junk;

    always #5 clk = ~clk;

    branch_resolve_predict #(
        .IDX_W(IW),
        .PC_W (PW),
        .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .res_valid     (res_valid),
        .res_pc        (res_pc),
        .res_funct3    (res_funct3),
        .res_pred_taken(res_pred_taken),
        .brun          (brun),
        .breq          (breq),
        .brlt          (brlt),
        .br_taken      (br_taken),
        .mispredict    (mispredict),
        .illegal_br    (illegal_br),
        .cnt_clr       (cnt_clr),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // Comparator: follows the DUT's brun; breq carries junk in unsigned mode.
    always_comb begin
        breq = brun ? junk : (opa == opb);
        brlt = brun ? (opa < opb) : ($signed(opa) < $signed(opb));
    end

    typedef struct {
        logic          brun;
        logic          taken;
        logic          mis;
        logic          ill;
        logic          pred;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: counter value 0..3 per entry, predict taken when >= 2.
    int mctr[16];
    int mb;
    int mm;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mctr[i] = 1;
        mb = 0;
        mm = 0;
    endfunction

    function automatic int midx(logic [31:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function automatic logic mpred(logic [31:0] pc);
        return mctr[midx(pc)] >= 2;
    endfunction

    function automatic logic ref_taken(logic [2:0] f3, logic [7:0] a, logic [7:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] rop();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return 8'h7f;
            3:       return 8'h80;
            default: return 8'hff;
        endcase
    endfunction

    always @(negedge clk) begin
        if (q.size() != 0) begin
            mon_e = q.pop_front();
            chk("brun",        32'(brun),        32'(mon_e.brun));
            chk("br_taken",    32'(br_taken),    32'(mon_e.taken));
            chk("mispredict",  32'(mispredict),  32'(mon_e.mis));
            chk("illegal_br",  32'(illegal_br),  32'(mon_e.ill));
            chk("pred_taken",  32'(pred_taken),  32'(mon_e.pred));
            chk("branch_cnt",  32'(branch_cnt),  32'(mon_e.bc));
            chk("mispred_cnt", 32'(mispred_cnt), 32'(mon_e.mc));
        end
    end

    task automatic step(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic [2:0] f3, input logic rpt, input logic [31:0] ppc,
                        input logic clr, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic lg;
        logic tk;
        rst_n          = r;
        res_valid      = rv;
        res_pc         = rpc;
        res_funct3     = f3;
        res_pred_taken = rpt;
        pred_pc        = ppc;
        cnt_clr        = clr;
        opa            = a;
        opb            = b;
        junk           = 1'($urandom_range(0, 1));
        if (!r) model_reset();
        lg      = !(f3 == 3'd2 || f3 == 3'd3);
        tk      = rv && lg && ref_taken(f3, a, b);
        e.brun  = (f3 == 3'd6 || f3 == 3'd7);
        e.taken = tk;
        e.ill   = rv && !lg;
        e.mis   = rv && lg && (tk != rpt);
        e.pred  = mpred(ppc);
        e.bc    = CW'(mb);
        e.mc    = CW'(mm);
        q.push_back(e);
        @(posedge clk);
        if (r) begin
            if (clr) begin
                mb = 0;
                mm = 0;
            end else begin
                if (rv && lg && mb < CMAX) mb++;
                if (e.mis && mm < CMAX) mm++;
            end
            if (rv && lg) begin
                if (tk) mctr[midx(rpc)] = (mctr[midx(rpc)] == 3) ? 3 : mctr[midx(rpc)] + 1;
                else    mctr[midx(rpc)] = (mctr[midx(rpc)] == 0) ? 0 : mctr[midx(rpc)] - 1;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] ppc;
        rst_n = 1'b0; res_valid = 1'b0; res_pc = '0; res_funct3 = '0;
        res_pred_taken = 1'b0; pred_pc = '0; cnt_clr = 1'b0;
        opa = '0; opb = '0; junk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        step(1, 0, 32'h0,   3'd0, 0, 32'h100, 0, 8'h00, 8'h00);
        step(1, 1, 32'h4,   3'd6, 1, 32'h4,   0, 8'h01, 8'hff);
        step(1, 1, 32'h8,   3'd0, 1, 32'h8,   0, 8'h7f, 8'h7f);
        step(1, 1, 32'hc,   3'd5, 0, 32'hc,   0, 8'h80, 8'h01);
        for (int i = 0; i < 3; i++)
            step(1, 1, 32'h100, 3'd0, mpred(32'h100), 32'h100, 0, 8'h01, 8'h01);
        for (int i = 0; i < 3; i++)
            step(1, 1, 32'h100, 3'd1, mpred(32'h100), 32'h100, 0, 8'h01, 8'h01);
        step(1, 1, 32'h10,  3'd0, 0, 32'h10,  0, 8'h00, 8'h00);
        step(1, 1, 32'h14,  3'd3, 1, 32'h14,  0, 8'h00, 8'h00);
        step(1, 0, 32'h0,   3'd0, 0, 32'h14,  0, 8'h00, 8'h00);
        step(1, 1, 32'h100, 3'd0, 0, 32'h100, 0, 8'h00, 8'h00);
        step(1, 1, 32'h40,  3'd0, 0, 32'h40,  0, 8'h00, 8'h00);
        step(1, 0, 32'h0,   3'd0, 0, 32'h80,  0, 8'h00, 8'h00);

        for (int i = 0; i < 40; i++)
            step(1, 1, 32'h24, 3'd4, 1'($urandom_range(0, 1)), 32'h24, 0, rop(), rop());
        step(1, 0, 32'h0,  3'd0, 0, 32'h24, 0, 8'h00, 8'h00);
        step(1, 1, 32'h28, 3'd0, 0, 32'h28, 1, 8'h01, 8'h01);
        step(1, 0, 32'h0,  3'd0, 0, 32'h28, 0, 8'h00, 8'h00);

        for (int i = 0; i < 3; i++)
            step(1, 1, 32'h20, 3'd7, 0, 32'h20, 0, 8'hff, 8'h00);
        step(1, 0, 32'h0,  3'd0, 0, 32'h20, 0, 8'h00, 8'h00);
        step(0, 1, 32'h20, 3'd7, 0, 32'h20, 0, 8'hff, 8'h00);
        step(1, 0, 32'h0,  3'd0, 0, 32'h20, 0, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++) begin
            rpc = 32'($urandom_range(0, 63)) << 2;
            ppc = ($urandom_range(0, 1) != 0) ? rpc : 32'($urandom_range(0, 63)) << 2;
            step(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) != 0), rpc,
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ppc,
                 ($urandom_range(0, 19) == 0), rop(), rop());
        end

        step(1, 0, 32'h0, 3'd0, 0, 32'h0, 0, 8'h00, 8'h00);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
